// File: rtl/memory_stage.sv
// EX/MEM pipeline register with a req/ack data-memory access that stalls the pipe until done.
// Optional MEM_ALIGN_CHECK_EN: misaligned load/store is rejected without a request.
module memory_stage #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter logic [31:0] BAD_DATA    = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ValidE,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        jumpE,
    input  logic [1:0]  MemtoRegE,
    input  logic [4:0]  WriteRegE,
    input  logic [31:0] ALUMultOutE,
    input  logic [31:0] WriteDataE,
    input  logic [31:0] PCPlus8E,
    input  logic        FlushM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        StallM,
    output logic        MemErrM,
    output logic        RegWriteM,
    output logic        jumpM,
    output logic [1:0]  MemtoRegM,
    output logic [4:0]  WriteRegM,
    output logic [31:0] ReadDataM,
    output logic [31:0] ALUMultOutM,
    output logic [31:0] PCPlus8M
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state, stateNext;
    logic             validQ, regWriteQ, memWriteQ, jumpQ;
    logic [1:0]       memtoRegQ;
    logic [4:0]       writeRegQ;
    logic [31:0]      aluQ, wdataQ, pc8Q, rdataQ;
    logic [CNT_W-1:0] cnt;
    logic             errQ;
    logic             memop, misaligned, capAck, abort;

    assign memop = validQ & (memWriteQ | (memtoRegQ == 2'b11));

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = |aluQ[1:0];
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        stateNext = state;
        dmem_req  = 1'b0;
        capAck    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (memop) begin
                    if (misaligned) begin
                        abort     = 1'b1;
                        stateNext = DONE;
                    end else begin
                        dmem_req = 1'b1;
                        if (dmem_ack) begin
                            capAck    = 1'b1;
                            stateNext = DONE;
                        end else begin
                            stateNext = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    capAck    = 1'b1;
                    stateNext = DONE;
                end else if (cnt == CNT_LAST) begin
                    abort     = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign StallM     = memop & (state != DONE);
    assign dmem_we    = dmem_req & memWriteQ;
    assign dmem_addr  = dmem_req ? aluQ : '0;
    assign dmem_wdata = dmem_req ? wdataQ : '0;

    // Writeback has no enable, so every stalled cycle must present a bubble.
    assign RegWriteM   = regWriteQ & validQ & ~StallM;
    assign MemErrM     = errQ;
    assign ReadDataM   = rdataQ;
    assign jumpM       = jumpQ;
    assign MemtoRegM   = memtoRegQ;
    assign WriteRegM   = writeRegQ;
    assign ALUMultOutM = aluQ;
    assign PCPlus8M    = pc8Q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            validQ    <= 1'b0;
            regWriteQ <= 1'b0;
            memWriteQ <= 1'b0;
            jumpQ     <= 1'b0;
            memtoRegQ <= '0;
            writeRegQ <= '0;
            aluQ      <= '0;
            wdataQ    <= '0;
            pc8Q      <= '0;
            rdataQ    <= '0;
            cnt       <= '0;
            errQ      <= 1'b0;
        end else begin
            state <= stateNext;
            errQ  <= abort;
            if (capAck)
                rdataQ <= dmem_rdata;
            else if (abort)
                rdataQ <= BAD_DATA;
            // Held at zero in IDLE so the timeout window restarts on every entry to WAIT.
            if (state == WAIT)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
            if (!StallM) begin
                validQ    <= ValidE & ~FlushM;
                regWriteQ <= RegWriteE;
                memWriteQ <= MemWriteE;
                jumpQ     <= jumpE;
                memtoRegQ <= MemtoRegE;
                writeRegQ <= WriteRegE;
                aluQ      <= ALUMultOutE;
                wdataQ    <= WriteDataE;
                pc8Q      <= PCPlus8E;
            end
        end
    end

endmodule
